bp_cfg_loader: RTL and testbench

BP_CFG_LOADER -- requirements
Module: bp_cfg_loader

---
 rtl/bp_cfg_loader.sv | 202 ++++++++++++++++++++
 tb/tb_bp_cfg_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: after start_i, writes freeze/core_id/cce_mode to every core, then unfreezes each core in order.
// Optional feature macro BP_CFG_LOADER_NPC_EN adds a per-core boot-PC (npc) write as the last CFG write.
module bp_cfg_loader #(
  parameter int num_core_p       = 2,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  localparam int core_w_lp       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic                        cce_mode_i,
  input  logic [39:0]                 npc_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_w_lp-1:0]        cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

`ifdef BP_CFG_LOADER_NPC_EN
  localparam logic [1:0] last_step_lp = 2'd3;
`else
  localparam logic [1:0] last_step_lp = 2'd2;
`endif
  localparam logic [core_w_lp-1:0] last_core_lp = core_w_lp'(num_core_p - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CFG      = 2'd1,
    UNFREEZE = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e                      r_state, w_state_n;
  logic [core_w_lp-1:0]        r_core, w_core_n;
  logic [1:0]                  r_step, w_step_n;
  logic                        r_cce_mode, w_cce_mode_n;
  logic                        w_hs;
  logic                        w_v_n, w_busy_n, w_done_n;
  logic [core_w_lp-1:0]        w_cfg_core_n;
  logic [cfg_addr_width_p-1:0] w_addr_n;
  logic [cfg_data_width_p-1:0] w_data_n;

`ifdef BP_CFG_LOADER_NPC_EN
  logic [39:0] r_npc, w_npc_n;
`else
  logic w_unused_npc;
  assign w_unused_npc = ^npc_i;
`endif

  assign w_hs = cfg_v_o & cfg_ready_i;

  // Next-state and counter update; counters only move on a handshake.
  always_comb begin
    w_state_n    = r_state;
    w_core_n     = r_core;
    w_step_n     = r_step;
    w_cce_mode_n = r_cce_mode;
`ifdef BP_CFG_LOADER_NPC_EN
    w_npc_n      = r_npc;
`endif
    case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          w_state_n    = CFG;
          w_core_n     = {core_w_lp{1'b0}};
          w_step_n     = 2'd0;
          w_cce_mode_n = cce_mode_i;
`ifdef BP_CFG_LOADER_NPC_EN
          w_npc_n      = npc_i;
`endif
        end else begin
          w_state_n = r_state;
        end
      end
      CFG: begin
        if (w_hs) begin
          if (r_step == last_step_lp) begin
            w_step_n = 2'd0;
            if (r_core == last_core_lp) begin
              w_core_n  = {core_w_lp{1'b0}};
              w_state_n = UNFREEZE;
            end else begin
              w_core_n = r_core + core_w_lp'(1);
            end
          end else begin
            w_step_n = r_step + 2'd1;
          end
        end else begin
          w_state_n = CFG;
        end
      end
      UNFREEZE: begin
        if (w_hs) begin
          if (r_core == last_core_lp) begin
            w_core_n  = {core_w_lp{1'b0}};
            w_state_n = DONE;
          end else begin
            w_core_n = r_core + core_w_lp'(1);
          end
        end else begin
          w_state_n = UNFREEZE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop aligned with the state.
  always_comb begin
    w_v_n        = 1'b0;
    w_busy_n     = 1'b0;
    w_done_n     = 1'b0;
    w_cfg_core_n = {core_w_lp{1'b0}};
    w_addr_n     = {cfg_addr_width_p{1'b0}};
    w_data_n     = {cfg_data_width_p{1'b0}};
    case (w_state_n)
      CFG: begin
        w_v_n        = 1'b1;
        w_busy_n     = 1'b1;
        w_cfg_core_n = w_core_n;
        case (w_step_n)
          2'd0: begin
            w_addr_n = cfg_addr_width_p'(16'h0001);
            w_data_n = cfg_data_width_p'(1'b1);
          end
          2'd1: begin
            w_addr_n = cfg_addr_width_p'(16'h0002);
            w_data_n = cfg_data_width_p'(w_core_n);
          end
          2'd2: begin
            w_addr_n = cfg_addr_width_p'(16'h0003);
            w_data_n = cfg_data_width_p'(w_cce_mode_n);
          end
`ifdef BP_CFG_LOADER_NPC_EN
          2'd3: begin
            w_addr_n = cfg_addr_width_p'(16'h0004);
            w_data_n = cfg_data_width_p'(w_npc_n);
          end
`endif
          default: begin
            w_addr_n = {cfg_addr_width_p{1'b0}};
            w_data_n = {cfg_data_width_p{1'b0}};
          end
        endcase
      end
      UNFREEZE: begin
        w_v_n        = 1'b1;
        w_busy_n     = 1'b1;
        w_cfg_core_n = w_core_n;
        w_addr_n     = cfg_addr_width_p'(16'h0001);
      end
      DONE:    w_done_n = 1'b1;
      IDLE:    w_done_n = 1'b0;
      default: w_done_n = 1'b0;
    endcase
  end

  // State, counters and sampled configuration values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= IDLE;
      r_core     <= {core_w_lp{1'b0}};
      r_step     <= 2'd0;
      r_cce_mode <= 1'b0;
`ifdef BP_CFG_LOADER_NPC_EN
      r_npc      <= 40'd0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_core     <= w_core_n;
      r_step     <= w_step_n;
      r_cce_mode <= w_cce_mode_n;
`ifdef BP_CFG_LOADER_NPC_EN
      r_npc      <= w_npc_n;
`endif
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cfg_v_o    <= 1'b0;
      cfg_core_o <= {core_w_lp{1'b0}};
      cfg_addr_o <= {cfg_addr_width_p{1'b0}};
      cfg_data_o <= {cfg_data_width_p{1'b0}};
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      cfg_v_o    <= w_v_n;
      cfg_core_o <= w_cfg_core_n;
      cfg_addr_o <= w_addr_n;
      cfg_data_o <= w_data_n;
      busy_o     <= w_busy_n;
      done_o     <= w_done_n;
    end
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Randomized self-checking bench for bp_cfg_loader; expected write order comes from a list-based model.
module tb_bp_cfg_loader;
  localparam int N  = 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
`ifdef BP_CFG_LOADER_NPC_EN
  localparam int W = 4;
`else
  localparam int W = 3;
`endif

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          start_i;
  logic          cce_mode_i;
  logic [39:0]   npc_i;
  logic          cfg_v_o;
  logic          cfg_ready_i;
  logic [CW-1:0] cfg_core_o;
  logic [15:0]   cfg_addr_o;
  logic [63:0]   cfg_data_o;
  logic          busy_o;
  logic          done_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [127:0] core;
    logic [127:0] addr;
    logic [127:0] data;
  } wr_t;

  bp_cfg_loader #(.num_core_p(N), .cfg_addr_width_p(16), .cfg_data_width_p(64)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .cce_mode_i(cce_mode_i),
    .npc_i(npc_i), .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_core_o(cfg_core_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_v"},    128'(cfg_v_o),    128'd0);
    check_eq({tag, "_core"}, 128'(cfg_core_o), 128'd0);
    check_eq({tag, "_addr"}, 128'(cfg_addr_o), 128'd0);
    check_eq({tag, "_data"}, 128'(cfg_data_o), 128'd0);
    check_eq({tag, "_busy"}, 128'(busy_o),     128'd0);
    check_eq({tag, "_done"}, 128'(done_o),     128'd0);
  endtask

  // One configuration sequence. stall_hs: handshake index held off for 5 cycles (-1 none);
  // poke_start: pulse start once phase 2 begins; abort_hs: return early after that many handshakes (-1 none).
  task automatic run_seq(input logic mode, input logic [39:0] npc, input int ready_pct,
                         input int stall_hs, input bit poke_start, input int abort_hs);
    wr_t q[$];
    wr_t w;
    wr_t held;
    int hs = 0;
    int budget = 0;
    int stall_left = 5;
    bit stalled = 1'b0;
    bit poked = 1'b0;
    bit rdy;
    for (int c = 0; c < N; c++) begin
      q.push_back('{core: 128'(c), addr: 128'd1, data: 128'd1});
      q.push_back('{core: 128'(c), addr: 128'd2, data: 128'(c)});
      q.push_back('{core: 128'(c), addr: 128'd3, data: 128'(mode)});
      if (W == 4) q.push_back('{core: 128'(c), addr: 128'd4, data: 128'(npc)});
    end
    for (int c = 0; c < N; c++) q.push_back('{core: 128'(c), addr: 128'd1, data: 128'd0});

    check_eq("pre_start_v", 128'(cfg_v_o), 128'd0);
    start_i = 1'b1; cce_mode_i = mode; npc_i = npc; cfg_ready_i = 1'b0;
    tick();
    start_i = 1'b0; cce_mode_i = ~mode; npc_i = ~npc;
    check_eq("start_v", 128'(cfg_v_o), 128'd1);
    check_eq("start_busy", 128'(busy_o), 128'd1);
    check_eq("start_done", 128'(done_o), 128'd0);

    while (q.size() > 0 && budget < 500) begin
      if (abort_hs >= 0 && hs == abort_hs) return;
      start_i = 1'b0;
      if (poke_start && !poked && hs == N * W) begin
        start_i = 1'b1; cce_mode_i = ~mode; poked = 1'b1;
      end
      if (hs == stall_hs && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        if (stall_hs == 1) begin
          check_eq("bp_core", 128'(cfg_core_o), 128'd0);
          check_eq("bp_addr", 128'(cfg_addr_o), 128'd2);
          check_eq("bp_data", 128'(cfg_data_o), 128'd0);
        end
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      cfg_ready_i = rdy;
      check_eq("v_busy", 128'({cfg_v_o, busy_o}), 128'd3);
      if (stalled) begin
        check_eq("hold_core", 128'(cfg_core_o), held.core);
        check_eq("hold_addr", 128'(cfg_addr_o), held.addr);
        check_eq("hold_data", 128'(cfg_data_o), held.data);
      end
      if (rdy) begin
        w = q.pop_front();
        check_eq("wr_core", 128'(cfg_core_o), w.core);
        check_eq("wr_addr", 128'(cfg_addr_o), w.addr);
        check_eq("wr_data", 128'(cfg_data_o), w.data);
        hs++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = '{core: 128'(cfg_core_o), addr: 128'(cfg_addr_o), data: 128'(cfg_data_o)};
      end
      tick();
      budget++;
    end
    start_i = 1'b0;
    cfg_ready_i = 1'b1;
    check_eq("timeout_left", 128'(q.size()), 128'd0);
    check_eq("hs_count", 128'(hs), 128'(N * (W + 1)));
    check_eq("done_v", 128'(cfg_v_o), 128'd0);
    check_eq("done_flag", 128'(done_o), 128'd1);
    check_eq("done_busy", 128'(busy_o), 128'd0);
    tick();
    check_eq("done_sticky", 128'(done_o), 128'd1);
    check_eq("done_quiet", 128'(cfg_v_o), 128'd0);
  endtask

  initial begin
    reset_n_i = 1'b0; start_i = 1'b0; cce_mode_i = 1'b0; npc_i = 40'd0; cfg_ready_i = 1'b0;
    tick();
    tick();
    check_zero_outputs("reset");
    reset_n_i = 1'b1;
    tick();
    check_eq("idle_v", 128'(cfg_v_o), 128'd0);
    check_eq("idle_done", 128'(done_o), 128'd0);

    // basic, then restart from DONE with backpressure on the second write
    run_seq(1'b1, 40'h0080000000, 100, -1, 1'b0, -1);
    run_seq(1'b1, 40'h0080000000, 100, 1, 1'b0, -1);
    // start pulsed during phase 2 must be ignored
    run_seq(1'(($urandom_range(1))), {8'($urandom_range(255)), 32'($urandom)}, 100, -1, 1'b1, -1);

    // mid-sequence asynchronous reset
    run_seq(1'b1, 40'h0012345678, 100, -1, 1'b0, 4);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_zero_outputs("abort");
    tick();
    #2;
    reset_n_i = 1'b1;
    cfg_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_reset_v", 128'(cfg_v_o), 128'd0);
      check_eq("post_reset_busy", 128'(busy_o), 128'd0);
    end
    run_seq(1'b0, 40'h0080000000, 100, -1, 1'b0, -1);

    // random backpressure and values
    for (int r = 0; r < 6; r++) begin
      run_seq(1'(($urandom_range(1))), {8'($urandom_range(255)), 32'($urandom)},
              40 + 10 * r, (r % 2 == 0) ? int'($urandom_range(N * (W + 1) - 1)) : -1,
              1'(r % 3 == 1), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
